spi_slave_sync: RTL and testbench

//  Parametrised SPI slave, fully synchronous to the system clock PCLK. SCK/SS/MOSI are

---
 rtl/spi_slave_sync.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync.sv
// SPI slave fully synchronous to PCLK: all CPOL/CPHA modes, TX holding register, RX FIFO.
// Define SPIS_XFER_CNT_EN to add the xfer_cnt completed-word counter output.
module spi_slave_sync #(
  parameter int DW          = 8,
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          CPOL,
  input  logic          CPHA,
  input  logic          SCK,
  input  logic          SS,
  input  logic          MOSI,
  output logic          MISO,
  output logic          MISO_OE,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          busy,
  input  logic          clr_flags,
  output logic          overrun,
  output logic          underrun
`ifdef SPIS_XFER_CNT_EN
  ,
  output logic [15:0]   xfer_cnt
`endif
);

  // state  | meaning
  // IDLE   | deselected, waiting for synced SS fall
  // ACTIVE | selected, sampling/shifting words
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, ss_prev_q;

  state_t                 state_q, state_d;
  logic                   cpol_q, cpol_d;
  logic                   cpha_q, cpha_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]          rx_shift_q, rx_shift_d;
  logic [DW-1:0]          tx_shift_q, tx_shift_d;
  logic                   load_pend_q, load_pend_d;
  logic                   skip_q, skip_d;

  logic [DW-1:0]          hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   underrun_q, underrun_d;
  logic                   overrun_q, overrun_d;

  logic [DW-1:0]          mem_q [RX_DEPTH];
  logic [DW-1:0]          mem_d [RX_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;

`ifdef SPIS_XFER_CNT_EN
  logic [15:0]            xfer_cnt_q, xfer_cnt_d;
`endif

  logic sck_s, ss_s, mosi_s;
  logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise;
  logic load, push_req, push, pop, fifo_full, accept;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Leading edge is SCK leaving its idle (CPOL) level.
  assign sck_edge    = sck_s ^ sck_prev_q;
  assign lead_edge   = sck_edge & (sck_s != cpol_q);
  assign trail_edge  = sck_edge & (sck_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  assign ss_fall     = ~ss_s & ss_prev_q;
  assign ss_rise     = ss_s & ~ss_prev_q;

  assign fifo_full = (count_q == (AW+1)'(RX_DEPTH));
  assign pop       = rx_ready & (count_q != '0);
  assign push      = push_req & (~fifo_full | pop);
  assign accept    = tx_valid & ~hold_full_q;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};

    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    load_pend_d = load_pend_q;
    skip_d      = skip_q;
    load        = 1'b0;
    push_req    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d     = ACTIVE;
          cpol_d      = CPOL;
          cpha_d      = CPHA;
          bit_cnt_d   = '0;
          load        = 1'b1;
          load_pend_d = 1'b0;
          skip_d      = CPHA;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          load_pend_d = 1'b0;
          skip_d      = 1'b0;
        end else if (sample_edge) begin
          rx_shift_d = {rx_shift_q[DW-2:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d   = '0;
            push_req    = 1'b1;
            load_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (shift_edge) begin
          // First shift edge of a word either loads the next word or, for CPHA=1's
          // opening word, is skipped because the MSB is already on MISO.
          if (load_pend_q) begin
            load        = 1'b1;
            load_pend_d = 1'b0;
          end else if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[DW-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) tx_shift_d = hold_full_q ? hold_q : '0;

    hold_d      = accept ? tx_data : hold_q;
    hold_full_d = accept | (hold_full_q & ~load);
    underrun_d  = (load & ~hold_full_q) | (underrun_q & ~clr_flags);
    overrun_d   = (push_req & fifo_full & ~pop) | (overrun_q & ~clr_flags);

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = rx_shift_d;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

`ifdef SPIS_XFER_CNT_EN
    xfer_cnt_d = (clr_flags ? 16'd0 : xfer_cnt_q) + 16'(push_req);
`endif
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      load_pend_q <= 1'b0;
      skip_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef SPIS_XFER_CNT_EN
      xfer_cnt_q  <= '0;
`endif
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      load_pend_q <= load_pend_d;
      skip_q      <= skip_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef SPIS_XFER_CNT_EN
      xfer_cnt_q  <= xfer_cnt_d;
`endif
    end
  end

  assign MISO_OE  = ~ss_s;
  assign MISO     = ~ss_s & tx_shift_q[DW-1];
  assign tx_ready = ~hold_full_q;
  assign rx_data  = mem_q[rd_ptr_q];
  assign rx_valid = (count_q != '0);
  assign busy     = (state_q == ACTIVE);
  assign overrun  = overrun_q;
  assign underrun = underrun_q;
`ifdef SPIS_XFER_CNT_EN
  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Self-checking bench for spi_slave_sync: bit-banged SPI master plus a queue-based
// model of TX word loads (holding register) and the RX FIFO.
module tb_spi_slave_sync;
  localparam int RX_DEPTH = 4;

  logic       PCLK = 1'b0;
  logic       PRESETn, CPOL, CPHA, SCK, SS, MOSI;
  logic       MISO, MISO_OE;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, busy, clr_flags, overrun, underrun;
`ifdef SPIS_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  spi_slave_sync #(.DW(8), .RX_DEPTH(RX_DEPTH), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .CPOL(CPOL), .CPHA(CPHA), .SCK(SCK), .SS(SS),
    .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .clr_flags(clr_flags), .overrun(overrun), .underrun(underrun)
`ifdef SPIS_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 PCLK = ~PCLK;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] feed_q[$];
  logic [7:0] txm_q[$];
  logic [7:0] rxm_q[$];
  bit         und_m = 1'b0;
  bit         ovr_m = 1'b0;
  logic [7:0] mosi_w[8];
  logic [7:0] miso_w[8];

  // Feeds queued words into the TX holding register as fast as it accepts them.
  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(posedge PCLK);
      if (PRESETn && tx_valid && tx_ready) void'(feed_q.pop_front());
      #1;
      if (feed_q.size() > 0) begin
        tx_data  = feed_q[0];
        tx_valid = 1'b1;
      end else begin
        tx_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge PCLK);
  endtask

  task automatic queue_tx(input logic [7:0] w);
    feed_q.push_back(w);
    txm_q.push_back(w);
  endtask

  // A word load takes the oldest offered word, or zero with underrun when none is left.
  function automatic logic [7:0] model_load();
    if (txm_q.size() > 0) return txm_q.pop_front();
    und_m = 1'b1;
    return 8'h00;
  endfunction

  task automatic xfer(input bit cp, input bit ch, input int nw, input int abort_bits,
                      input bit chk_rdy);
    int idx;
    CPOL = cp; CPHA = ch; SCK = cp;
    repeat (6) @(negedge PCLK);
    SS = 1'b0;
    if (!ch) MOSI = mosi_w[0][7];
    half();
    CPOL = ~cp; CPHA = ~ch;
    chk("busy_selected", 32'(busy), 32'd1);
    chk("oe_selected", 32'(MISO_OE), 32'd1);
    if (chk_rdy) chk("tx_ready_after_load", 32'(tx_ready), 32'd1);
    for (int k = 0; k < nw * 8; k++) begin
      if (abort_bits > 0 && k == abort_bits) break;
      if (!ch) begin
        miso_w[k/8][7-(k%8)] = MISO;
        SCK = ~cp;
        half();
        SCK = cp;
        idx = k + 1;
        if (idx < nw * 8) MOSI = mosi_w[idx/8][7-(idx%8)];
        half();
      end else begin
        SCK  = ~cp;
        MOSI = mosi_w[k/8][7-(k%8)];
        half();
        miso_w[k/8][7-(k%8)] = MISO;
        SCK = cp;
        half();
      end
    end
    SS = 1'b1;
    half();
    CPOL = cp; CPHA = ch;
    chk("busy_deselected", 32'(busy), 32'd0);
    chk("oe_deselected", 32'(MISO_OE), 32'd0);
  endtask

  task automatic full_xfer(input bit cp, input bit ch, input int nw, input bit chk_rdy,
                           input string tag);
    logic [7:0] exp_tx[8];
    for (int w = 0; w < nw; w++) exp_tx[w] = model_load();
    // CPHA=0 loads again on the trailing edge that ends the last word.
    if (!ch) void'(model_load());
    for (int w = 0; w < nw; w++) begin
      if (rxm_q.size() < RX_DEPTH) rxm_q.push_back(mosi_w[w]);
      else ovr_m = 1'b1;
    end
    xfer(cp, ch, nw, 0, chk_rdy);
    for (int w = 0; w < nw; w++) chk({tag, "_miso"}, 32'(miso_w[w]), 32'(exp_tx[w]));
    chk({tag, "_underrun"}, 32'(underrun), 32'(und_m));
    chk({tag, "_overrun"}, 32'(overrun), 32'(ovr_m));
  endtask

  task automatic drain(input string tag);
    while (rxm_q.size() > 0) begin
      @(negedge PCLK);
      chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd1);
      chk({tag, "_rx_data"}, 32'(rx_data), 32'(rxm_q.pop_front()));
      rx_ready = 1'b1;
      @(negedge PCLK);
      rx_ready = 1'b0;
    end
    @(negedge PCLK);
    chk({tag, "_rx_empty"}, 32'(rx_valid), 32'd0);
  endtask

  task automatic clear_flags();
    @(negedge PCLK);
    clr_flags = 1'b1;
    @(negedge PCLK);
    clr_flags = 1'b0;
    und_m = 1'b0;
    ovr_m = 1'b0;
  endtask

  initial begin
    bit cp, ch;
    int nw, ntx;
    PRESETn = 1'b0; CPOL = 1'b0; CPHA = 1'b0; SCK = 1'b0; SS = 1'b1; MOSI = 1'b0;
    rx_ready = 1'b0; clr_flags = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_miso", 32'({MISO, MISO_OE}), 32'd0);
    chk("rst_flags", 32'({overrun, underrun}), 32'd0);
    PRESETn = 1'b1;
    repeat (3) @(negedge PCLK);

    // Mode 0 single word
    queue_tx(8'h3C);
    repeat (6) @(negedge PCLK);
    chk("t1_tx_ready_full", 32'(tx_ready), 32'd0);
    mosi_w[0] = 8'hA5;
    full_xfer(1'b0, 1'b0, 1, 1'b1, "t1");
    drain("t1");
    clear_flags();

    // Mode 3 back-to-back words
    queue_tx(8'hF0);
    queue_tx(8'h0F);
    mosi_w[0] = 8'h12; mosi_w[1] = 8'h34;
    full_xfer(1'b1, 1'b1, 2, 1'b0, "t2");
    drain("t2");
    clear_flags();

    // FIFO overrun with rx_ready held low
    for (int i = 0; i < 5; i++) mosi_w[i] = 8'(i + 1);
    full_xfer(1'b0, 1'b0, 5, 1'b0, "t3");
    clear_flags();
    @(negedge PCLK);
    chk("t3_overrun_cleared", 32'(overrun), 32'd0);
    chk("t3_underrun_cleared", 32'(underrun), 32'd0);
    drain("t3");

    // Mode 1 with nothing queued
    mosi_w[0] = 8'($urandom);
    full_xfer(1'b0, 1'b1, 1, 1'b0, "t4");
    drain("t4");
    clear_flags();

    // SS raised mid-word, then a full word
    mosi_w[0] = 8'($urandom);
    void'(model_load());
    xfer(1'b0, 1'b0, 1, 3, 1'b0);
    chk("t5_no_push", 32'(rx_valid), 32'd0);
    mosi_w[0] = 8'h5A;
    full_xfer(1'b0, 1'b0, 1, 1'b0, "t5");
    drain("t5");
    clear_flags();

    // Reset mid-word with a word already in the FIFO
    mosi_w[0] = 8'h77;
    full_xfer(1'b0, 1'b0, 1, 1'b0, "t6pre");
    CPOL = 1'b0; CPHA = 1'b0; SCK = 1'b0;
    repeat (4) @(negedge PCLK);
    SS = 1'b0; MOSI = 1'b1;
    half(); SCK = 1'b1; half(); SCK = 1'b0; half(); SCK = 1'b1; half();
    PRESETn = 1'b0;
    @(negedge PCLK);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_tx_ready", 32'(tx_ready), 32'd1);
    chk("t6_rx_valid", 32'(rx_valid), 32'd0);
    chk("t6_rx_data", 32'(rx_data), 32'd0);
    chk("t6_flags", 32'({overrun, underrun}), 32'd0);
    chk("t6_miso", 32'({MISO, MISO_OE}), 32'd0);
    SS = 1'b1; SCK = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    feed_q.delete(); txm_q.delete(); rxm_q.delete();
    und_m = 1'b0; ovr_m = 1'b0;
    repeat (3) @(negedge PCLK);
    queue_tx(8'h99);
    mosi_w[0] = 8'hC3;
    full_xfer(1'b0, 1'b0, 1, 1'b0, "t6post");
    drain("t6post");
    clear_flags();

    // Randomized transfers
    for (int it = 0; it < 8; it++) begin
      cp  = 1'($urandom_range(0, 1));
      ch  = 1'($urandom_range(0, 1));
      nw  = int'($urandom_range(1, 3));
      ntx = int'($urandom_range(0, nw + 1));
      for (int i = 0; i < ntx; i++) queue_tx(8'($urandom));
      for (int i = 0; i < nw; i++) mosi_w[i] = 8'($urandom);
      full_xfer(cp, ch, nw, 1'b0, "rnd");
      drain("rnd");
      clear_flags();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
